// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI shift engine between NREQ requesters.
// Owns the chip selects, sequences setup/hold/gap timing and aborts hung transfers.
module spi_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned BITS      = 8,
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned HOLD_CYC  = 2,
   parameter int unsigned GAP_CYC   = 4,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*BITS-1:0] tx_data,
   output logic [NREQ-1:0]      ack,
   output logic                 err,
   output logic [BITS-1:0]      rx_data,
   output logic [NREQ-1:0]      ss_n,
   output logic                 busy,
   output logic                 eng_start,
   output logic [BITS-1:0]      eng_tx,
   input  logic                 eng_done,
   input  logic [BITS-1:0]      eng_rx
);

   // Zero-length phases still occupy one cycle of their state.
   localparam int unsigned SETUP_N = (SETUP_CYC > 0) ? SETUP_CYC : 1;
   localparam int unsigned HOLD_N  = (HOLD_CYC > 0) ? HOLD_CYC : 1;
   localparam int unsigned GAP_N   = (GAP_CYC > 0) ? GAP_CYC : 1;
   localparam int unsigned TO_N    = (TIMEOUT > 0) ? TIMEOUT : 1;
   localparam int unsigned M1      = (TO_N > SETUP_N) ? TO_N : SETUP_N;
   localparam int unsigned M2      = (HOLD_N > GAP_N) ? HOLD_N : GAP_N;
   localparam int unsigned CNT_MAX = (M1 > M2) ? M1 : M2;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam int unsigned PW      = $clog2(NREQ);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      START = 3'd2,
      XFER  = 3'd3,
      HOLD  = 3'd4,
      GAP   = 3'd5
   } state_t;

   state_t          st, st_d;
   logic [CW-1:0]   cnt, cnt_d;
   logic [PW-1:0]   gnt, gnt_d;
   logic [PW-1:0]   ptr, ptr_d;
   logic [BITS-1:0] rx_buf, rx_buf_d;
   logic            err_buf, err_buf_d;
   logic [BITS-1:0] eng_tx_d, rx_data_d;
   logic [NREQ-1:0] ack_d, ss_n_d;
   logic            err_d, busy_d, eng_start_d;

   logic [PW-1:0]   pick;
   logic            found;
   logic [PW:0]     idx;
   logic [BITS-1:0] tx_sel;

   // Round-robin search: first set request at or above the pointer, with wrap.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = {1'b0, ptr} + (PW+1)'(i);
         if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
         if (!found && req[PW'(idx)]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
   end

   always_comb begin
      tx_sel = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick == PW'(i)) tx_sel = tx_data[i*BITS +: BITS];
      end
   end

   // Next state plus next values of every registered output.
   always_comb begin
      st_d        = st;
      cnt_d       = cnt + CW'(1);
      gnt_d       = gnt;
      ptr_d       = ptr;
      rx_buf_d    = rx_buf;
      err_buf_d   = err_buf;
      eng_tx_d    = eng_tx;
      rx_data_d   = rx_data;
      ack_d       = '0;
      err_d       = 1'b0;
      ss_n_d      = '1;
      busy_d      = 1'b0;
      eng_start_d = 1'b0;

      unique case (st)
         IDLE: begin
            cnt_d = '0;
            if (found) begin
               gnt_d    = pick;
               eng_tx_d = tx_sel;
               ptr_d    = (pick == PW'(NREQ - 1)) ? '0 : pick + PW'(1);
               st_d     = SETUP;
            end
         end
         SETUP: begin
            if (cnt == CW'(SETUP_N - 1)) begin
               st_d  = START;
               cnt_d = '0;
            end
         end
         START: begin
            st_d  = XFER;
            cnt_d = '0;
         end
         XFER: begin
            if (eng_done) begin
               rx_buf_d  = eng_rx;
               err_buf_d = 1'b0;
               st_d      = HOLD;
               cnt_d     = '0;
            end else if (cnt == CW'(TO_N - 1)) begin
               rx_buf_d  = '0;
               err_buf_d = 1'b1;
               st_d      = HOLD;
               cnt_d     = '0;
            end
         end
         HOLD: begin
            if (cnt == CW'(HOLD_N - 1)) begin
               st_d       = GAP;
               cnt_d      = '0;
               ack_d[gnt] = 1'b1;
               err_d      = err_buf;
               rx_data_d  = rx_buf;
            end
         end
         GAP: begin
            if (cnt == CW'(GAP_N - 1)) begin
               st_d  = IDLE;
               cnt_d = '0;
            end
         end
         default: begin
            st_d  = IDLE;
            cnt_d = '0;
         end
      endcase

      if (st_d == SETUP || st_d == START || st_d == XFER || st_d == HOLD)
         ss_n_d[gnt_d] = 1'b0;
      eng_start_d = (st_d == START);
      busy_d      = (st_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= IDLE;
         cnt       <= '0;
         gnt       <= '0;
         ptr       <= '0;
         rx_buf    <= '0;
         err_buf   <= 1'b0;
         eng_tx    <= '0;
         rx_data   <= '0;
         ack       <= '0;
         err       <= 1'b0;
         ss_n      <= '1;
         busy      <= 1'b0;
         eng_start <= 1'b0;
      end else begin
         st        <= st_d;
         cnt       <= cnt_d;
         gnt       <= gnt_d;
         ptr       <= ptr_d;
         rx_buf    <= rx_buf_d;
         err_buf   <= err_buf_d;
         eng_tx    <= eng_tx_d;
         rx_data   <= rx_data_d;
         ack       <= ack_d;
         err       <= err_d;
         ss_n      <= ss_n_d;
         busy      <= busy_d;
         eng_start <= eng_start_d;
      end
   end

endmodule
